slow_domain_bridge: RTL and testbench

- Rate adapter directly downstream of the clock generator.
- Runs entirely on original_clock and observes clock_slower as a synchronous level input.
- Buffers words from a fast-side valid/ready producer in a FIFO and presents one word per clock_slower period to slow-domain logic.
- Updates its output on the falling edge of clock_slower, so the data is stable at the next slow rising edge.

---
 rtl/slow_domain_bridge.sv | 139 +++++++++++++
 tb/tb_slow_domain_bridge.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_domain_bridge.sv
// slow_domain_bridge: fast-side FIFO feeding a slow domain one word per
// clock_slower period, all logic clocked by original_clock.
//
// Ports:
//   original_clock - sole clock, rising edge
//   reset_in       - asynchronous active-low reset
//   clock_slower   - divided clock, sampled as a level
//   in_valid/in_ready/in_data - fast-side producer handshake
//   slow_data/slow_valid      - word for the current slow period
//   slow_tick      - one-cycle pulse per detected slow falling edge
//   fifo_count     - current occupancy
//   ratio_err      - sticky period error (only with RATIO_CHECK_EN)
//
// Optional: define RATIO_CHECK_EN to add the slow period checker.
module slow_domain_bridge #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int RATIO  = 5
) (
   input  logic                     original_clock,
   input  logic                     reset_in,
   input  logic                     clock_slower,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   output logic [DATA_W-1:0]        slow_data,
   output logic                     slow_valid,
   output logic                     slow_tick,
   output logic [$clog2(DEPTH):0]   fifo_count
`ifdef RATIO_CHECK_EN
   ,
   output logic                     ratio_err
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr;
   logic [AW-1:0]     r_rd;
   logic [AW:0]       r_count;
   logic              r_slow_q;
   logic [DATA_W-1:0] r_slow_data;
   logic              r_slow_valid;
   logic              r_slow_tick;

   logic w_fall;
   logic w_push;
   logic w_pop;

   assign w_fall = r_slow_q & ~clock_slower;
   // Ready uses the pre-pop count, so a full FIFO refuses a push
   // even on the cycle a word leaves.
   assign in_ready = (r_count != FULL);
   assign w_push   = in_valid & in_ready;
   assign w_pop    = w_fall & (r_count != '0);

   assign slow_data  = r_slow_data;
   assign slow_valid = r_slow_valid;
   assign slow_tick  = r_slow_tick;
   assign fifo_count = r_count;

   // Storage carries no reset; occupancy and pointers define contents.
   always_ff @(posedge original_clock) begin
      if (w_push) begin
         r_mem[r_wr] <= in_data;
      end
   end

   always_ff @(posedge original_clock or negedge reset_in) begin
      if (!reset_in) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wr <= r_wr + 1'b1;
         end
         if (w_pop) begin
            r_rd <= r_rd + 1'b1;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge original_clock or negedge reset_in) begin
      if (!reset_in) begin
         r_slow_q     <= 1'b0;
         r_slow_tick  <= 1'b0;
         r_slow_data  <= '0;
         r_slow_valid <= 1'b0;
      end else begin
         r_slow_q    <= clock_slower;
         r_slow_tick <= w_fall;
         // An empty FIFO at a fall keeps the old word but marks it stale.
         if (w_fall) begin
            r_slow_valid <= w_pop;
            if (w_pop) begin
               r_slow_data <= r_mem[r_rd];
            end
         end
      end
   end

`ifdef RATIO_CHECK_EN
   // A full slow period spans 2*RATIO cycles, so the counter cleared
   // at one fall reads 2*RATIO-1 at the next one.
   localparam int EXP_I = (2*RATIO-1 > 255) ? 255 : 2*RATIO-1;
   localparam logic [7:0] EXP_CNT = 8'(EXP_I);

   logic [7:0] r_per_cnt;
   logic       r_seen;
   logic       r_ratio_err;

   assign ratio_err = r_ratio_err;

   always_ff @(posedge original_clock or negedge reset_in) begin
      if (!reset_in) begin
         r_per_cnt   <= '0;
         r_seen      <= 1'b0;
         r_ratio_err <= 1'b0;
      end else if (w_fall) begin
         r_per_cnt <= '0;
         r_seen    <= 1'b1;
         if (r_seen && (r_per_cnt != EXP_CNT)) begin
            r_ratio_err <= 1'b1;
         end
      end else if (r_per_cnt != 8'hFF) begin
         r_per_cnt <= r_per_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_slow_domain_bridge.sv
// tb_slow_domain_bridge: scenario tasks checked against a queue-based
// model of the bridge, plus directed expectations from the test plan.
module tb_slow_domain_bridge;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int RATIO = 5;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          original_clock = 1'b0;
   logic          reset_in       = 1'b0;
   logic          clock_slower   = 1'b0;
   logic          in_valid       = 1'b0;
   logic [DW-1:0] in_data        = '0;
   logic          in_ready;
   logic [DW-1:0] slow_data;
   logic          slow_valid;
   logic          slow_tick;
   logic [CW-1:0] fifo_count;
`ifdef RATIO_CHECK_EN
   logic          ratio_err;
`endif

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_data;
   logic          m_valid, m_tick, m_prev, m_err, m_seen;
   int            cyc, last_fall;

   bit auto_slow = 1'b1;
   int half_len  = RATIO;
   int s_cnt     = 0;

   localparam int VW = DW + 3 + CW;
   logic [VW-1:0] act_v, exp_v;

   slow_domain_bridge #(.DATA_W(DW), .DEPTH(DEPTH), .RATIO(RATIO)) dut (
      .original_clock(original_clock),
      .reset_in      (reset_in),
      .clock_slower  (clock_slower),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .slow_data     (slow_data),
      .slow_valid    (slow_valid),
      .slow_tick     (slow_tick),
      .fifo_count    (fifo_count)
`ifdef RATIO_CHECK_EN
      ,
      .ratio_err     (ratio_err)
`endif
   );

   always #5 original_clock = ~original_clock;

   task automatic model_reset();
      mq.delete();
      m_data = '0; m_valid = 0; m_tick = 0; m_prev = 0;
      m_err = 0; m_seen = 0; cyc = 0; last_fall = 0;
   endtask

   // Advance one clock: predict from current inputs, step, move slow clock.
   task automatic tick();
      bit fall, push;
      if (!reset_in) begin
         model_reset();
      end else begin
         fall = m_prev && !clock_slower;
         push = in_valid && (mq.size() != DEPTH);
         if (fall) begin
            if (mq.size() != 0) begin
               m_data  = mq.pop_front();
               m_valid = 1;
            end else begin
               m_valid = 0;
            end
            if (m_seen && (cyc - last_fall) != 2*RATIO) m_err = 1;
            m_seen    = 1;
            last_fall = cyc;
         end
         if (push) mq.push_back(in_data);
         m_tick = fall;
         m_prev = clock_slower;
         cyc++;
      end
      @(posedge original_clock);
      #1;
      act_v = {slow_data, slow_valid, slow_tick, fifo_count, in_ready};
      exp_v = {m_data, m_valid, m_tick, CW'(mq.size()),
               mq.size() != DEPTH};
      if (auto_slow) begin
         s_cnt++;
         if (s_cnt >= half_len) begin
            clock_slower = ~clock_slower;
            s_cnt = 0;
         end
      end
   endtask

   task automatic test_reset();
      int tcs[$];
      bit ok;
      reset_in = 0; auto_slow = 1; half_len = RATIO; s_cnt = 0;
      clock_slower = 0; in_valid = 0;
      model_reset();
      repeat (3) tick();
      checks++;
      if ({slow_data, slow_valid, slow_tick, fifo_count, in_ready} !==
          {32'h0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
         errors++;
         $display("FAIL reset_vals got %h want %h",
                  {slow_data, slow_valid, slow_tick, fifo_count, in_ready},
                  {32'h0, 1'b0, 1'b0, 4'd0, 1'b1});
      end
      reset_in = 1;
      for (int i = 0; i < 60; i++) begin
         tick();
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL reset_run cyc %0d got %h want %h", i, act_v, exp_v);
         end
         if (slow_tick) tcs.push_back(i);
      end
      ok = tcs.size() >= 5;
      for (int k = 1; k < tcs.size(); k++)
         if (tcs[k] - tcs[k-1] != 10) ok = 0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL tick_spacing got %0d ticks want spacing 10",
                  tcs.size());
      end
   endtask

   task automatic test_back_to_back();
      int got = 0;
      bit seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick();
         seen = slow_tick;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL b2b_wait got no tick want tick");
      end
      for (int k = 0; k < 3; k++) begin
         in_valid = 1;
         in_data  = 32'hA1 + k;
         tick();
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL b2b_push got %h want %h", act_v, exp_v);
         end
      end
      in_valid = 0;
      for (int i = 0; i < 60 && got < 4; i++) begin
         tick();
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL b2b_run got %h want %h", act_v, exp_v);
         end
         if (slow_tick) begin
            checks++;
            if (got < 3) begin
               if ({slow_valid, slow_data} !== {1'b1, 32'hA1 + got}) begin
                  errors++;
                  $display("FAIL b2b_word%0d got %h want %h", got,
                           {slow_valid, slow_data}, {1'b1, 32'hA1 + got});
               end
            end else if ({slow_valid, slow_data} !== {1'b0, 32'hA3}) begin
               errors++;
               $display("FAIL b2b_empty got %h want %h",
                        {slow_valid, slow_data}, {1'b0, 32'hA3});
            end
            got++;
         end
      end
      checks++;
      if (got != 4) begin
         errors++;
         $display("FAIL b2b_falls got %0d want 4", got);
      end
   endtask

   task automatic test_full();
      logic [DW-1:0] first = '0;
      auto_slow = 0; clock_slower = 1;
      in_valid = 1;
      for (int i = 0; i < 12; i++) begin
         in_data = $urandom;
         if (i == 0) first = in_data;
         tick();
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL full_fill %0d got %h want %h", i, act_v, exp_v);
         end
         if (i >= 7) begin
            checks++;
            if ({in_ready, fifo_count} !== {1'b0, 4'd8}) begin
               errors++;
               $display("FAIL full_state %0d got %h want %h", i,
                        {in_ready, fifo_count}, {1'b0, 4'd8});
            end
         end
      end
      clock_slower = 0;
      in_data = $urandom;
      tick();
      checks++;
      if ({in_ready, fifo_count, slow_valid, slow_tick, slow_data} !==
          {1'b1, 4'd7, 1'b1, 1'b1, first}) begin
         errors++;
         $display("FAIL full_pop got %h want %h",
                  {in_ready, fifo_count, slow_valid, slow_tick, slow_data},
                  {1'b1, 4'd7, 1'b1, 1'b1, first});
      end
      in_valid = 0; auto_slow = 1; s_cnt = 0;
      for (int i = 0; i < 90; i++) begin
         tick();
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL full_drain %0d got %h want %h", i, act_v, exp_v);
         end
      end
   endtask

   task automatic test_push_on_fall();
      logic [DW-1:0] w;
      bit seen = 0;
      auto_slow = 0; clock_slower = 1;
      repeat (2) tick();
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL pof_pre got %h want %h", act_v, exp_v);
      end
      clock_slower = 0; in_valid = 1;
      w = $urandom; in_data = w;
      tick();
      in_valid = 0;
      checks++;
      if ({slow_tick, slow_valid, fifo_count} !== {1'b1, 1'b0, 4'd1}) begin
         errors++;
         $display("FAIL pof_same got %h want %h",
                  {slow_tick, slow_valid, fifo_count}, {1'b1, 1'b0, 4'd1});
      end
      auto_slow = 1; s_cnt = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick();
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL pof_run got %h want %h", act_v, exp_v);
         end
         if (slow_tick) begin
            seen = 1;
            checks++;
            if ({slow_valid, slow_data} !== {1'b1, w}) begin
               errors++;
               $display("FAIL pof_word got %h want %h",
                        {slow_valid, slow_data}, {1'b1, w});
            end
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL pof_timeout got no fall want fall");
      end
   endtask

   task automatic test_reset_mid();
      int vcnt = 0;
      auto_slow = 0; clock_slower = 1; in_valid = 1;
      repeat (5) begin
         in_data = $urandom;
         tick();
      end
      in_valid = 0;
      tick();
      checks++;
      if (fifo_count !== 4'd5) begin
         errors++;
         $display("FAIL mid_fill got %0d want 5", fifo_count);
      end
      #2;
      reset_in = 0;
      model_reset();
      #1;
      checks++;
      if ({slow_data, slow_valid, slow_tick, fifo_count, in_ready} !==
          {32'h0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
         errors++;
         $display("FAIL mid_async got %h want %h",
                  {slow_data, slow_valid, slow_tick, fifo_count, in_ready},
                  {32'h0, 1'b0, 1'b0, 4'd0, 1'b1});
      end
      repeat (2) tick();
      reset_in = 1; auto_slow = 1; s_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL mid_run %0d got %h want %h", i, act_v, exp_v);
         end
         if (slow_valid) vcnt++;
      end
      checks++;
      if (vcnt != 0) begin
         errors++;
         $display("FAIL mid_stale got %0d valid cycles want 0", vcnt);
      end
   endtask

   task automatic test_random();
      auto_slow = 1;
      for (int i = 0; i < 400; i++) begin
         in_valid = (i < 200) ? ($urandom_range(0, 3) != 0)
                              : ($urandom_range(0, 9) == 0);
         in_data  = $urandom;
         tick();
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL rand %0d got %h want %h", i, act_v, exp_v);
         end
      end
      in_valid = 0;
   endtask

`ifdef RATIO_CHECK_EN
   task automatic test_ratio();
      int lens[10] = '{5, 5, 5, 5, 5, 5, 4, 5, 5, 5};
      reset_in = 0; auto_slow = 0; clock_slower = 0; in_valid = 0;
      model_reset();
      repeat (2) tick();
      reset_in = 1;
      for (int s = 0; s < 10; s++) begin
         clock_slower = (s % 2 == 0);
         for (int j = 0; j < lens[s]; j++) begin
            tick();
            checks++;
            if (ratio_err !== m_err) begin
               errors++;
               $display("FAIL ratio seg %0d got %b want %b",
                        s, ratio_err, m_err);
            end
         end
      end
      checks++;
      if (ratio_err !== 1'b1) begin
         errors++;
         $display("FAIL ratio_sticky got %b want 1", ratio_err);
      end
      reset_in = 0;
      #1;
      checks++;
      if (ratio_err !== 1'b0) begin
         errors++;
         $display("FAIL ratio_reset got %b want 0", ratio_err);
      end
      model_reset();
      tick();
      reset_in = 1;
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_full();
      test_push_on_fall();
      test_reset_mid();
      test_random();
`ifdef RATIO_CHECK_EN
      test_ratio();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
